// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one mmio port between two valid/ready masters,
// with a per-tenure access cap so a continuously requesting master cannot starve the other.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              memwrite,
  output logic              memread,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW:0] CAP = (CW+1)'(MAX_BURST);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state;
  logic last;
  logic [CW-1:0] count;
  logic own0, own1, vx, vy, cap_hit;
  logic [CW:0] next_count;
  // x is the current owner, y the other requester; both default to port 0 view in IDLE
  always_comb begin
    own0       = state == OWN0;
    own1       = state == OWN1;
    vx         = own1 ? req1_valid : req0_valid;
    vy         = own1 ? req0_valid : req1_valid;
    next_count = {1'b0, count} + (CW+1)'(1);
    cap_hit    = next_count >= CAP;
  end
  assign req0_ready    = own0 & req0_valid;
  assign req1_ready    = own1 & req1_valid;
  assign req0_rdata    = own0 ? mem_readdata : '0;
  assign req1_rdata    = own1 ? mem_readdata : '0;
  assign memwrite      = own0 ? req0_valid & req0_write : own1 & req1_valid & req1_write;
  assign memread       = own0 ? req0_valid & ~req0_write : own1 & req1_valid & ~req1_write;
  assign mem_addr      = own0 ? req0_addr : own1 ? req1_addr : '0;
  assign mem_writedata = own0 ? req0_wdata : own1 ? req1_wdata : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last  <= 1'b1;
      count <= '0;
    end else if (state == IDLE) begin
      count <= '0;
      if (req0_valid && (!req1_valid || last)) state <= OWN0;
      else if (req1_valid) state <= OWN1;
    end else if (vy && (!vx || cap_hit)) begin
      state <= own1 ? OWN0 : OWN1;
      last  <= own1;
      count <= '0;
    end else if (!vx) begin
      state <= IDLE;
      last  <= own1;
      count <= '0;
    end else if ({1'b0, count} < CAP) begin
      count <= next_count[CW-1:0];
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors against a small mmio memory model, expected values hand-derived.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [7:0]  req0_addr, req1_addr, mem_addr;
  logic [31:0] req0_wdata, req1_wdata, req0_rdata, req1_rdata;
  logic        req0_ready, req1_ready, memwrite, memread;
  logic [31:0] mem_writedata, mem_readdata;
  logic [31:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rdata(req1_rdata),
    .memwrite(memwrite), .memread(memread), .mem_addr(mem_addr),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;
  assign mem_readdata = mem[mem_addr];
  always @(posedge clk) if (memwrite) mem[mem_addr] <= mem_writedata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                       input logic v1, input logic w1, input logic [7:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_memwrite"}, {31'b0, memwrite}, 32'd0);
    chk({tag, "_memread"}, {31'b0, memread}, 32'd0);
    chk({tag, "_ready0"}, {31'b0, req0_ready}, 32'd0);
    chk({tag, "_ready1"}, {31'b0, req1_ready}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h00] = 32'hFFFF_FFFF;
    mem[8'h20] = 32'h1234_5678;
    reset = 1'b0;
    drive(1, 1, 8'h00, 32'hCAFE_F00D, 1, 0, 8'h00, 32'h0);
    #2;
    quiet("rst");
    chk("rst_addr", {24'b0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_writedata, 32'd0);
    chk("rst_rdata0", req0_rdata, 32'd0);
    chk("rst_rdata1", req1_rdata, 32'd0);
    tick();
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      quiet("idle10");
    end
    // single master: write, read back, then keep reading with no contention
    drive(1, 1, 8'h10, 32'hDEAD_BEEF, 0, 0, 8'h00, 32'h0);
    #1;
    chk("wr_t_ready0", {31'b0, req0_ready}, 32'd0);
    tick();
    chk("wr_memwrite", {31'b0, memwrite}, 32'd1);
    chk("wr_memread", {31'b0, memread}, 32'd0);
    chk("wr_addr", {24'b0, mem_addr}, 32'h10);
    chk("wr_wdata", mem_writedata, 32'hDEAD_BEEF);
    chk("wr_ready0", {31'b0, req0_ready}, 32'd1);
    tick();
    drive(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0);
    #1;
    chk("rd_memread", {31'b0, memread}, 32'd1);
    chk("rd_ready0", {31'b0, req0_ready}, 32'd1);
    chk("rd_rdata0", req0_rdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_ready0", {31'b0, req0_ready}, 32'd1);
      chk("sat_rdata0", req0_rdata, 32'hDEAD_BEEF);
    end
    tick();
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    #1;
    quiet("own0_idle");
    chk("mem10", mem[8'h10], 32'hDEAD_BEEF);
    tick();
    tick();
    // reset restores last=1, so a tie goes to req0; then 4/4 rotation with no idle cycle
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive(1, 0, 8'h10, 32'h0, 1, 0, 8'h20, 32'h0);
    #1;
    quiet("tie_t");
    for (int k = 1; k <= 17; k++) begin
      logic o0;
      o0 = ((k - 1) / 4) % 2 == 0;
      tick();
      chk("rr_ready0", {31'b0, req0_ready}, {31'b0, o0});
      chk("rr_ready1", {31'b0, req1_ready}, {31'b0, !o0});
      chk("rr_memread", {31'b0, memread}, 32'd1);
      chk("rr_rdata", o0 ? req0_rdata : req1_rdata, o0 ? 32'hDEAD_BEEF : 32'h1234_5678);
    end
    tick();
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    #1;
    quiet("rr_end");
    tick();
    // owner release: req1 alone, drops valid, back to IDLE with last=1
    drive(0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0);
    #1;
    chk("rel_t_ready1", {31'b0, req1_ready}, 32'd0);
    tick();
    chk("rel_ready1", {31'b0, req1_ready}, 32'd1);
    chk("rel_rdata1", req1_rdata, 32'h1234_5678);
    chk("rel_rdata0", req0_rdata, 32'd0);
    tick();
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    #1;
    quiet("rel_own1_idle");
    tick();
    drive(1, 0, 8'h10, 32'h0, 1, 0, 8'h20, 32'h0);
    #1;
    quiet("rel_idle");
    tick();
    chk("rel_tie_ready0", {31'b0, req0_ready}, 32'd1);
    chk("rel_tie_ready1", {31'b0, req1_ready}, 32'd0);
    tick();
    drive(0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0);
    #1;
    quiet("rel_own0_idle");
    tick();
    chk("rel_hand_ready1", {31'b0, req1_ready}, 32'd1);
    chk("rel_hand_rdata1", req1_rdata, 32'h1234_5678);
    tick();
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    tick();
    // reset during a req1 write before its commit edge
    tick();
    drive(0, 0, 8'h00, 32'h0, 1, 1, 8'h20, 32'hBAD0_BAD0);
    tick();
    chk("mid_memwrite", {31'b0, memwrite}, 32'd1);
    chk("mid_addr", {24'b0, mem_addr}, 32'h20);
    #1;
    reset = 1'b0;
    #1;
    quiet("mid_rst");
    chk("mid_rst_addr", {24'b0, mem_addr}, 32'd0);
    chk("mid_rst_wdata", mem_writedata, 32'd0);
    chk("mid_rst_rdata1", req1_rdata, 32'd0);
    tick();
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    reset = 1'b1;
    chk("mid_mem20", mem[8'h20], 32'h1234_5678);
    tick();
    drive(1, 0, 8'h20, 32'h0, 0, 0, 8'h00, 32'h0);
    tick();
    chk("mid_rd_ready0", {31'b0, req0_ready}, 32'd1);
    chk("mid_rd_rdata0", req0_rdata, 32'h1234_5678);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
